// File: rtl/cpu_ctrl_pkg.sv
// cpu_ctrl_pkg
// Shared definitions for the accumulator-machine control unit: the FSM state
// enum, the ISA opcode map, the ALU opcode encoding, the datapath mux select
// encodings and the packed strobe bundle passed from the decoder to the top.
package cpu_ctrl_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_FETCH_MAR,
    ST_FETCH_MEM,
    ST_LOAD_IR,
    ST_DECODE,
    ST_EXEC_MAR,
    ST_EXEC_MEM,
    ST_WRITEBACK,
    ST_STORE_WR,
    ST_HALTED
  } state_e;

  // ISA opcodes, IR[15:12]
  localparam logic [3:0] OP_NOP     = 4'h0;
  localparam logic [3:0] OP_LOAD    = 4'h1;
  localparam logic [3:0] OP_STORE   = 4'h2;
  localparam logic [3:0] OP_ADD     = 4'h3;
  localparam logic [3:0] OP_SUB     = 4'h4;
  localparam logic [3:0] OP_AND     = 4'h5;
  localparam logic [3:0] OP_OR      = 4'h6;
  localparam logic [3:0] OP_XOR     = 4'h7;
  localparam logic [3:0] OP_JUMP    = 4'h8;
  localparam logic [3:0] OP_SKIPZ   = 4'h9;
  localparam logic [3:0] OP_SKIPNEG = 4'hA;
  localparam logic [3:0] OP_SHL     = 4'hB;
  localparam logic [3:0] OP_SHR     = 4'hC;
  localparam logic [3:0] OP_LOADI   = 4'hD;
  localparam logic [3:0] OP_RSVD    = 4'hE;
  localparam logic [3:0] OP_HALT    = 4'hF;

  // ALU opcodes as understood by the datapath ALU
  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_SHL = 4'b0100;
  localparam logic [3:0] ALU_SHR = 4'b0101;
  localparam logic [3:0] ALU_AND = 4'b1000;
  localparam logic [3:0] ALU_OR  = 4'b1001;
  localparam logic [3:0] ALU_XOR = 4'b1010;

  // Datapath mux selects
  localparam logic [1:0] ACC_SEL_ALU = 2'd0;
  localparam logic [1:0] ACC_SEL_MBR = 2'd1;
  localparam logic [1:0] ACC_SEL_IMM = 2'd2;
  localparam logic       MBR_SEL_MEM = 1'b0;
  localparam logic       MBR_SEL_ACC = 1'b1;
  localparam logic       MAR_SEL_PC  = 1'b0;
  localparam logic       MAR_SEL_IR  = 1'b1;
  localparam logic       PC_SEL_INC  = 1'b0;
  localparam logic       PC_SEL_IR   = 1'b1;

  // One cycle worth of datapath control
  typedef struct packed {
    logic       pc_write;
    logic       pc_sel;
    logic       mar_write;
    logic       mar_sel;
    logic       mbr_write;
    logic       mbr_sel;
    logic       ir_write;
    logic       acc_write;
    logic [1:0] acc_sel;
    logic [3:0] alu_op;
    logic       mem_read;
    logic       mem_write;
  } ctrl_t;

endpackage

// File: rtl/cpu_ctrl_if.sv
// cpu_ctrl_if
// Bundle between the control unit and the datapath/memory.
//   master : control unit side (consumes start, IR opcode and ACC flags;
//            drives write strobes, mux selects, ALU opcode, memory strobes,
//            busy/halted/illegal status and the retired-instruction count)
//   slave  : datapath/system side, directions reversed
interface cpu_ctrl_if #(
  parameter int CNT_W = 16
);

  logic             start;
  logic [3:0]       ir_opcode;
  logic             acc_zero;
  logic             acc_neg;

  logic             pc_write;
  logic             pc_sel;
  logic             mar_write;
  logic             mar_sel;
  logic             mbr_write;
  logic             mbr_sel;
  logic             ir_write;
  logic             acc_write;
  logic [1:0]       acc_sel;
  logic [3:0]       alu_op;
  logic             mem_read;
  logic             mem_write;
  logic             busy;
  logic             halted;
  logic             illegal;
  logic [CNT_W-1:0] instr_retired;

  modport master (
    input  start, ir_opcode, acc_zero, acc_neg,
    output pc_write, pc_sel, mar_write, mar_sel, mbr_write, mbr_sel,
           ir_write, acc_write, acc_sel, alu_op, mem_read, mem_write,
           busy, halted, illegal, instr_retired
  );

  modport slave (
    output start, ir_opcode, acc_zero, acc_neg,
    input  pc_write, pc_sel, mar_write, mar_sel, mbr_write, mbr_sel,
           ir_write, acc_write, acc_sel, alu_op, mem_read, mem_write,
           busy, halted, illegal, instr_retired
  );

endinterface

// File: rtl/cpu_ctrl_decode.sv
// cpu_ctrl_decode
// Purely combinational: maps the current FSM state (plus opcode and ACC flags
// where they matter) to this cycle's strobe bundle and the next state.
//   state_i      current FSM state
//   start_i      run request, only looked at in IDLE
//   memLast_i    final wait cycle of a memory read
//   execStore_i  instruction in flight is a STORE (captured in DECODE)
//   ir_opcode_i  IR[15:12]
//   acc_zero_i / acc_neg_i  ACC status flags
//   ctrl_o       strobes/selects for this cycle
//   nextState_o  state to enter at the next clock edge
//   retire_o     instruction completes this cycle
//   setIllegal_o reserved opcode reached DECODE
module cpu_ctrl_decode
  import cpu_ctrl_pkg::*;
(
  input  state_e     state_i,
  input  logic       start_i,
  input  logic       memLast_i,
  input  logic       execStore_i,
  input  logic [3:0] ir_opcode_i,
  input  logic       acc_zero_i,
  input  logic       acc_neg_i,
  output ctrl_t      ctrl_o,
  output state_e     nextState_o,
  output logic       retire_o,
  output logic       setIllegal_o
);

  always_comb begin
    ctrl_o       = '0;
    nextState_o  = state_i;
    retire_o     = 1'b0;
    setIllegal_o = 1'b0;

    case (state_i)
      ST_IDLE: begin
        if (start_i) nextState_o = ST_FETCH_MAR;
      end

      ST_FETCH_MAR: begin
        ctrl_o.mar_write = 1'b1;
        ctrl_o.mar_sel   = MAR_SEL_PC;
        nextState_o      = ST_FETCH_MEM;
      end

      // The read strobe is held for the whole latency window; MBR only
      // captures once the memory data is valid.
      ST_FETCH_MEM: begin
        ctrl_o.mem_read = 1'b1;
        if (memLast_i) begin
          ctrl_o.mbr_write = 1'b1;
          ctrl_o.mbr_sel   = MBR_SEL_MEM;
          nextState_o      = ST_LOAD_IR;
        end
      end

      ST_LOAD_IR: begin
        ctrl_o.ir_write = 1'b1;
        ctrl_o.pc_write = 1'b1;
        ctrl_o.pc_sel   = PC_SEL_INC;
        nextState_o     = ST_DECODE;
      end

      // Register-only instructions finish here; memory-operand ones move on.
      ST_DECODE: begin
        retire_o    = 1'b1;
        nextState_o = ST_FETCH_MAR;
        case (ir_opcode_i)
          OP_NOP: ;
          OP_JUMP: begin
            ctrl_o.pc_write = 1'b1;
            ctrl_o.pc_sel   = PC_SEL_IR;
          end
          OP_SKIPZ: begin
            ctrl_o.pc_write = acc_zero_i;
            ctrl_o.pc_sel   = PC_SEL_INC;
          end
          OP_SKIPNEG: begin
            ctrl_o.pc_write = acc_neg_i;
            ctrl_o.pc_sel   = PC_SEL_INC;
          end
          OP_SHL: begin
            ctrl_o.acc_write = 1'b1;
            ctrl_o.acc_sel   = ACC_SEL_ALU;
            ctrl_o.alu_op    = ALU_SHL;
          end
          OP_SHR: begin
            ctrl_o.acc_write = 1'b1;
            ctrl_o.acc_sel   = ACC_SEL_ALU;
            ctrl_o.alu_op    = ALU_SHR;
          end
          OP_LOADI: begin
            ctrl_o.acc_write = 1'b1;
            ctrl_o.acc_sel   = ACC_SEL_IMM;
          end
          OP_HALT: nextState_o = ST_HALTED;
          OP_RSVD: begin
            retire_o     = 1'b0;
            setIllegal_o = 1'b1;
            nextState_o  = ST_HALTED;
          end
          default: begin
            retire_o    = 1'b0;
            nextState_o = ST_EXEC_MAR;
          end
        endcase
      end

      // STORE loads MBR from ACC in parallel with the address load so the
      // write can go out on the very next cycle.
      ST_EXEC_MAR: begin
        ctrl_o.mar_write = 1'b1;
        ctrl_o.mar_sel   = MAR_SEL_IR;
        if (execStore_i) begin
          ctrl_o.mbr_write = 1'b1;
          ctrl_o.mbr_sel   = MBR_SEL_ACC;
          nextState_o      = ST_STORE_WR;
        end else begin
          nextState_o      = ST_EXEC_MEM;
        end
      end

      ST_EXEC_MEM: begin
        ctrl_o.mem_read = 1'b1;
        if (memLast_i) begin
          ctrl_o.mbr_write = 1'b1;
          ctrl_o.mbr_sel   = MBR_SEL_MEM;
          nextState_o      = ST_WRITEBACK;
        end
      end

      ST_WRITEBACK: begin
        retire_o    = 1'b1;
        nextState_o = ST_FETCH_MAR;
        ctrl_o.acc_write = 1'b1;
        case (ir_opcode_i)
          OP_LOAD: ctrl_o.acc_sel = ACC_SEL_MBR;
          OP_ADD:  ctrl_o.alu_op  = ALU_ADD;
          OP_SUB:  ctrl_o.alu_op  = ALU_SUB;
          OP_AND:  ctrl_o.alu_op  = ALU_AND;
          OP_OR:   ctrl_o.alu_op  = ALU_OR;
          OP_XOR:  ctrl_o.alu_op  = ALU_XOR;
          default: ctrl_o.acc_write = 1'b0;
        endcase
      end

      ST_STORE_WR: begin
        ctrl_o.mem_write = 1'b1;
        retire_o         = 1'b1;
        nextState_o      = ST_FETCH_MAR;
      end

      ST_HALTED: ;

      default: nextState_o = ST_IDLE;
    endcase
  end

endmodule

// File: rtl/cpu_control_unit.sv
// cpu_control_unit
// Multi-cycle fetch/decode/execute sequencer for the 16-bit accumulator
// datapath. Holds the FSM state, the memory wait counter, the sticky illegal
// flag and the retired-instruction counter; per-cycle strobes come from
// cpu_ctrl_decode.
//   clock  rising-edge system clock
//   reset  asynchronous, active-low
//   bus    cpu_ctrl_if master modport (inputs start/ir_opcode/acc flags,
//          outputs strobes, selects, alu_op, busy/halted/illegal/count)
// MEM_LATENCY must lie in 1..15 (the wait counter is 4 bits wide).
module cpu_control_unit
  import cpu_ctrl_pkg::*;
#(
  parameter int MEM_LATENCY = 1,
  parameter int CNT_W       = 16
) (
  input logic        clock,
  input logic        reset,
  cpu_ctrl_if.master bus
);

  state_e           state_q, state_d;
  logic [3:0]       wait_q, wait_d;
  logic             illegal_q, illegal_d;
  logic             execStore_q, execStore_d;
  logic [CNT_W-1:0] retired_q, retired_d;

  ctrl_t  ctrl;
  state_e nextState;
  logic   retire;
  logic   setIllegal;
  logic   memLast;
  logic   inMemWait;

  assign inMemWait = (state_q == ST_FETCH_MEM) || (state_q == ST_EXEC_MEM);
  assign memLast   = (wait_q == 4'(MEM_LATENCY - 1));

  cpu_ctrl_decode u_decode (
    .state_i      (state_q),
    .start_i      (bus.start),
    .memLast_i    (memLast),
    .execStore_i  (execStore_q),
    .ir_opcode_i  (bus.ir_opcode),
    .acc_zero_i   (bus.acc_zero),
    .acc_neg_i    (bus.acc_neg),
    .ctrl_o       (ctrl),
    .nextState_o  (nextState),
    .retire_o     (retire),
    .setIllegal_o (setIllegal)
  );

  // Next-state for all registers. The STORE/other split is captured in
  // DECODE so that IR changes outside DECODE/WRITEBACK cannot redirect
  // EXEC_MAR.
  always_comb begin
    state_d     = nextState;
    wait_d      = 4'd0;
    illegal_d   = illegal_q | setIllegal;
    execStore_d = execStore_q;
    retired_d   = retired_q;

    if (inMemWait && !memLast) wait_d = wait_q + 4'd1;
    if (state_q == ST_DECODE)  execStore_d = (bus.ir_opcode == OP_STORE);
    if (retire)                retired_d = retired_q + CNT_W'(1);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      wait_q      <= 4'd0;
      illegal_q   <= 1'b0;
      execStore_q <= 1'b0;
      retired_q   <= '0;
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      illegal_q   <= illegal_d;
      execStore_q <= execStore_d;
      retired_q   <= retired_d;
    end
  end

  assign bus.pc_write      = ctrl.pc_write;
  assign bus.pc_sel        = ctrl.pc_sel;
  assign bus.mar_write     = ctrl.mar_write;
  assign bus.mar_sel       = ctrl.mar_sel;
  assign bus.mbr_write     = ctrl.mbr_write;
  assign bus.mbr_sel       = ctrl.mbr_sel;
  assign bus.ir_write      = ctrl.ir_write;
  assign bus.acc_write     = ctrl.acc_write;
  assign bus.acc_sel       = ctrl.acc_sel;
  assign bus.alu_op        = ctrl.alu_op;
  assign bus.mem_read      = ctrl.mem_read;
  assign bus.mem_write     = ctrl.mem_write;
  assign bus.busy          = (state_q != ST_IDLE) && (state_q != ST_HALTED);
  assign bus.halted        = (state_q == ST_HALTED);
  assign bus.illegal       = illegal_q;
  assign bus.instr_retired = retired_q;

endmodule

// File: tb/tb_cpu_control_unit.sv
// tb_cpu_control_unit
// Scoreboard bench: the stimulus side builds each instruction's expected
// cycle-by-cycle control trace from the ISA timing rules and queues it; a
// monitor pops and compares one entry on every busy cycle.
module tb_cpu_control_unit;

  localparam int L = 3;

  logic clock = 1'b0;
  logic reset = 1'b0;

  always #5 clock = ~clock;

  cpu_ctrl_if #(.CNT_W(16)) bus ();

  cpu_control_unit #(.MEM_LATENCY(L), .CNT_W(16)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct packed {
    logic        pcW;
    logic        pcS;
    logic        marW;
    logic        marS;
    logic        mbrW;
    logic        mbrS;
    logic        irW;
    logic        accW;
    logic [1:0]  accS;
    logic [3:0]  alu;
    logic        memR;
    logic        memW;
    logic        busy;
    logic        halted;
    logic        illegal;
    logic [15:0] retired;
  } vec_t;

  vec_t  scbQ[$];
  string nameQ[$];
  int    vectors     = 0;
  int    miscompares = 0;
  int    modelCount  = 0;

  function automatic vec_t busVec();
    vec_t v;
    v.pcW     = bus.pc_write;
    v.pcS     = bus.pc_sel;
    v.marW    = bus.mar_write;
    v.marS    = bus.mar_sel;
    v.mbrW    = bus.mbr_write;
    v.mbrS    = bus.mbr_sel;
    v.irW     = bus.ir_write;
    v.accW    = bus.acc_write;
    v.accS    = bus.acc_sel;
    v.alu     = bus.alu_op;
    v.memR    = bus.mem_read;
    v.memW    = bus.mem_write;
    v.busy    = bus.busy;
    v.halted  = bus.halted;
    v.illegal = bus.illegal;
    v.retired = bus.instr_retired;
    return v;
  endfunction

  function automatic vec_t restVec(input int cnt, input bit h, input bit ill);
    vec_t v;
    v         = '0;
    v.halted  = h;
    v.illegal = ill;
    v.retired = 16'(cnt);
    return v;
  endfunction

  task automatic checkOutput(input string name, input vec_t got, input vec_t exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Monitor: one scoreboard entry per busy cycle, sampled mid-cycle
  initial begin
    forever begin
      @(negedge clock);
      if (reset && bus.busy) begin
        if (scbQ.size() == 0) begin
          checkOutput("unexpected busy cycle", busVec(), '0);
        end else begin
          vec_t  e;
          string n;
          e = scbQ.pop_front();
          n = nameQ.pop_front();
          checkOutput(n, busVec(), e);
        end
      end
    end
  end

  // Issue one instruction: build its expected trace, then drive it cycle by
  // cycle. Opcode and flags carry real values only where the sequencer is
  // meant to look at them; elsewhere they are randomised. abortAt >= 0
  // pulls reset low in that cycle instead of finishing the instruction.
  task automatic applyStimulus(input logic [3:0] op, input bit zf, input bit nf,
                               input int abortAt, output bit stopped);
    vec_t seq[$];
    vec_t v, c;
    int   decodeIdx;
    int   wbIdx;
    bit   memOp;
    memOp     = (op >= 4'h1) && (op <= 4'h7);
    v         = '0;
    v.busy    = 1'b1;
    v.retired = 16'(modelCount);
    wbIdx     = -1;

    c = v; c.marW = 1'b1; seq.push_back(c);
    for (int i = 0; i < L; i++) begin
      c = v; c.memR = 1'b1; c.mbrW = (i == L - 1); seq.push_back(c);
    end
    c = v; c.irW = 1'b1; c.pcW = 1'b1; seq.push_back(c);

    decodeIdx = seq.size();
    c = v;
    case (op)
      4'h8: begin c.pcW = 1'b1; c.pcS = 1'b1; end
      4'h9: c.pcW = zf;
      4'hA: c.pcW = nf;
      4'hB: begin c.accW = 1'b1; c.alu = 4'b0100; end
      4'hC: begin c.accW = 1'b1; c.alu = 4'b0101; end
      4'hD: begin c.accW = 1'b1; c.accS = 2'd2; end
      default: ;
    endcase
    seq.push_back(c);

    if (memOp) begin
      c = v; c.marW = 1'b1; c.marS = 1'b1;
      if (op == 4'h2) begin c.mbrW = 1'b1; c.mbrS = 1'b1; end
      seq.push_back(c);
      if (op == 4'h2) begin
        c = v; c.memW = 1'b1; seq.push_back(c);
      end else begin
        for (int i = 0; i < L; i++) begin
          c = v; c.memR = 1'b1; c.mbrW = (i == L - 1); seq.push_back(c);
        end
        c = v; c.accW = 1'b1;
        case (op)
          4'h1: c.accS = 2'd1;
          4'h3: c.alu = 4'b0000;
          4'h4: c.alu = 4'b0001;
          4'h5: c.alu = 4'b1000;
          4'h6: c.alu = 4'b1001;
          default: c.alu = 4'b1010;
        endcase
        wbIdx = seq.size();
        seq.push_back(c);
      end
    end

    stopped = 1'b0;
    for (int k = 0; k < seq.size(); k++) begin
      bus.ir_opcode = (k == decodeIdx || k == wbIdx) ? op : 4'($urandom);
      bus.acc_zero  = (k == decodeIdx) ? zf : 1'($urandom);
      bus.acc_neg   = (k == decodeIdx) ? nf : 1'($urandom);
      bus.start     = 1'($urandom);
      if (k == abortAt) begin
        #1 reset = 1'b0;
        #1 checkOutput($sformatf("async reset clear op%h c%0d", op, k), busVec(), '0);
        scbQ.delete();
        nameQ.delete();
        modelCount = 0;
        stopped    = 1'b1;
        return;
      end
      scbQ.push_back(seq[k]);
      nameQ.push_back($sformatf("op%h cycle%0d", op, k));
      @(posedge clock);
      #1;
    end
    if (op != 4'hE) modelCount++;
  endtask

  task automatic startRun();
    @(posedge clock);
    #1 bus.start = 1'b1;
    @(posedge clock);
    #1;
  endtask

  task automatic resetDut();
    #1 reset = 1'b0;
    bus.start = 1'b0;
    @(negedge clock);
    reset      = 1'b1;
    modelCount = 0;
  endtask

  task automatic waitDrain();
    for (int i = 0; i < 20 && scbQ.size() != 0; i++) @(negedge clock);
    if (scbQ.size() != 0) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL drain: got %0d pending expected 0", scbQ.size());
      scbQ.delete();
      nameQ.delete();
    end
  endtask

  task automatic finishProgram(input bit ill);
    waitDrain();
    checkOutput("halted state", busVec(), restVec(modelCount, 1'b1, ill));
    bus.start = 1'b1;
    repeat (3) @(posedge clock);
    #1 checkOutput("start ignored when halted", busVec(), restVec(modelCount, 1'b1, ill));
    bus.start = 1'b0;
  endtask

  initial begin
    logic [3:0] dirOps[$];
    bit         dirZ[$];
    bit         dirN[$];
    bit         stopped;
    bus.start     = 1'b0;
    bus.ir_opcode = 4'h0;
    bus.acc_zero  = 1'b0;
    bus.acc_neg   = 1'b0;

    repeat (3) @(posedge clock);
    #1 checkOutput("reset state", busVec(), '0);
    @(negedge clock);
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1 checkOutput("idle without start", busVec(), '0);

    dirOps = '{4'h1, 4'h3, 4'h2, 4'h8, 4'h9, 4'h9, 4'hA, 4'hA, 4'hB, 4'hC,
               4'hD, 4'h0, 4'h4, 4'h5, 4'h6, 4'h7, 4'hF};
    dirZ   = '{0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    dirN   = '{0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    startRun();
    foreach (dirOps[i]) applyStimulus(dirOps[i], dirZ[i], dirN[i], -1, stopped);
    finishProgram(1'b0);

    for (int p = 0; p < 4; p++) begin
      int n;
      resetDut();
      startRun();
      n = $urandom_range(5, 12);
      for (int i = 0; i < n; i++)
        applyStimulus(4'($urandom_range(0, 13)), 1'($urandom), 1'($urandom), -1, stopped);
      applyStimulus((p % 2 == 1) ? 4'hE : 4'hF, 1'b0, 1'b0, -1, stopped);
      finishProgram(p % 2 == 1);
    end

    // Reset during EXEC_MEM of a LOAD, then during STORE_WR of a STORE
    for (int t = 0; t < 2; t++) begin
      resetDut();
      startRun();
      applyStimulus(4'h0, 1'b0, 1'b0, -1, stopped);
      applyStimulus((t == 0) ? 4'h1 : 4'h2, 1'b0, 1'b0, L + 4, stopped);
      bus.start = 1'b0;
      @(negedge clock);
      reset = 1'b1;
      repeat (2) @(posedge clock);
      #1 checkOutput("idle after reset release", busVec(), '0);
      startRun();
      applyStimulus(4'h3, 1'b0, 1'b0, -1, stopped);
      applyStimulus(4'hF, 1'b0, 1'b0, -1, stopped);
      finishProgram(1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
